// File: rtl/stopwatch_time_counter.sv
// BCD MM:SS stopwatch counter with run/pause/clear control and a lap-hold display snapshot.
// Driven by a 1-cycle tick from the clock divider; all outputs are registered.
module stopwatch_time_counter #(
    parameter bit SATURATE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    localparam int unsigned DIGIT_W = 4;

    typedef struct packed {
        logic [DIGIT_W-1:0] min_tens;
        logic [DIGIT_W-1:0] min_ones;
        logic [DIGIT_W-1:0] sec_tens;
        logic [DIGIT_W-1:0] sec_ones;
    } bcd_time_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    state_t    state_q, state_d;
    bcd_time_t live_q, live_d;
    bcd_time_t snap_q, snap_d;
    bcd_time_t disp_q, disp_d;
    bcd_time_t live_inc;
    logic      lap_q, lap_d;
    logic      ovf_q, ovf_d;
    logic      running_q;
    logic      wrap;

    // BCD carry chain: next value of the live count and whether it passes 59:59
    always_comb begin
        live_inc = live_q;
        wrap     = 1'b0;
        if (live_q.sec_ones == DIGIT_W'(9)) begin
            live_inc.sec_ones = '0;
            if (live_q.sec_tens == DIGIT_W'(5)) begin
                live_inc.sec_tens = '0;
                if (live_q.min_ones == DIGIT_W'(9)) begin
                    live_inc.min_ones = '0;
                    if (live_q.min_tens == DIGIT_W'(5)) begin
                        live_inc.min_tens = '0;
                        wrap              = 1'b1;
                    end else begin
                        live_inc.min_tens = live_q.min_tens + DIGIT_W'(1);
                    end
                end else begin
                    live_inc.min_ones = live_q.min_ones + DIGIT_W'(1);
                end
            end else begin
                live_inc.sec_tens = live_q.sec_tens + DIGIT_W'(1);
            end
        end else begin
            live_inc.sec_ones = live_q.sec_ones + DIGIT_W'(1);
        end
        if (wrap && SATURATE) begin
            live_inc = live_q;
        end
    end

    // Control FSM plus count/snapshot/lap next-state; clear dominates everything but reset
    always_comb begin
        state_d = state_q;
        live_d  = live_q;
        snap_d  = snap_q;
        lap_d   = lap_q;
        ovf_d   = 1'b0;
        if (clear) begin
            state_d = IDLE;
            live_d  = '0;
            snap_d  = '0;
            lap_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_stop) state_d = RUNNING;
                end
                RUNNING: begin
                    if (start_stop) state_d = PAUSED;
                    if (tick) begin
                        live_d = live_inc;
                        ovf_d  = wrap;
                    end
                    if (lap) begin
                        lap_d = ~lap_q;
                        if (!lap_q) snap_d = live_q;
                    end
                end
                PAUSED: begin
                    if (start_stop) state_d = RUNNING;
                    if (lap) lap_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
        disp_d = lap_d ? snap_d : live_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            live_q    <= '0;
            snap_q    <= '0;
            disp_q    <= '0;
            lap_q     <= 1'b0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            live_q    <= live_d;
            snap_q    <= snap_d;
            disp_q    <= disp_d;
            lap_q     <= lap_d;
            ovf_q     <= ovf_d;
            running_q <= (state_d == RUNNING);
        end
    end

    assign sec_ones   = disp_q.sec_ones;
    assign sec_tens   = disp_q.sec_tens;
    assign min_ones   = disp_q.min_ones;
    assign min_tens   = disp_q.min_tens;
    assign running    = running_q;
    assign lap_active = lap_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for stopwatch_time_counter: a wrapping and a saturating instance share stimulus.
module tb_stopwatch_time_counter;

    logic       clk = 1'b0;
    logic       rst, tick, start_stop, clear, lap;
    logic [3:0] so0, st0, mo0, mt0, so1, st1, mo1, mt1;
    logic       run0, lapa0, ovf0, run1, lapa1, ovf1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    stopwatch_time_counter #(.SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
        .sec_ones(so0), .sec_tens(st0), .min_ones(mo0), .min_tens(mt0),
        .running(run0), .lap_active(lapa0), .overflow(ovf0)
    );

    stopwatch_time_counter #(.SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
        .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1),
        .running(run1), .lap_active(lapa1), .overflow(ovf1)
    );

    wire [15:0] disp0 = {mt0, mo0, st0, so0};
    wire [15:0] disp1 = {mt1, mo1, st1, so1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic t, input logic ss, input logic clr, input logic lp);
        tick = t; start_stop = ss; clear = clr; lap = lp;
        @(posedge clk);
        #1;
        tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;

        // 1: reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            tick = 1'($urandom); start_stop = 1'($urandom); clear = 1'($urandom); lap = 1'($urandom);
            @(posedge clk);
            #1;
        end
        tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        check("rst_disp", 32'(disp0), 32'h0000);
        check("rst_flags", {29'd0, run0, lapa0, ovf0}, 32'd0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // 2: 75 ticks -> 01:15
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("start_running", 32'(run0), 32'd1);
        ticks(75);
        check("t75_disp", 32'(disp0), 32'h0115);
        check("t75_running", 32'(run0), 32'd1);

        // 3: carry boundaries, wrap and saturate
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("clear_idle", {30'd0, run0, run1}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(599);
        check("t599_disp", 32'(disp0), 32'h0959);
        ticks(1);
        check("t600_disp", 32'(disp0), 32'h1000);
        ticks(2999);
        check("t3599_wrap", 32'(disp0), 32'h5959);
        check("t3599_sat", 32'(disp1), 32'h5959);
        check("t3599_no_ovf", {30'd0, ovf0, ovf1}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("wrap_disp", 32'(disp0), 32'h0000);
        check("wrap_ovf", 32'(ovf0), 32'd1);
        check("sat_disp", 32'(disp1), 32'h5959);
        check("sat_ovf", 32'(ovf1), 32'd1);
        check("ovf_running", {30'd0, run0, run1}, 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_one_cycle", {30'd0, ovf0, ovf1}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_again_disp", 32'(disp1), 32'h5959);
        check("sat_again_ovf", {30'd0, ovf0, ovf1}, 32'd1);
        check("wrap_after_disp", 32'(disp0), 32'h0001);

        // 4: pause preserves count
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(20);
        check("pre_pause", 32'(disp0), 32'h0020);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("paused_running", 32'(run0), 32'd0);
        ticks(10);
        check("paused_disp", 32'(disp0), 32'h0020);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("resume_tick_ignored", 32'(disp0), 32'h0020);
        check("resume_running", 32'(run0), 32'd1);
        ticks(3);
        check("resume_disp", 32'(disp0), 32'h0023);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("stop_tick_counted", 32'(disp0), 32'h0024);
        check("stop_running", 32'(run0), 32'd0);

        // 5: lap freeze
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("lap_set", 32'(lapa0), 32'd1);
        ticks(5);
        check("lap_frozen", 32'(disp0), 32'h0010);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("lap_release_disp", 32'(disp0), 32'h0015);
        check("lap_release_flag", 32'(lapa0), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("lap_tick_snapshot", 32'(disp0), 32'h0015);
        ticks(2);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("lap_paused_frozen", 32'(disp0), 32'h0015);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("lap_paused_clear", {27'd0, lapa0, disp0[11:0] == 12'h018}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("lap_paused_no_capture", 32'(lapa0), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("clear_during_lap", {15'd0, lapa0, disp0}, 32'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("lap_idle_ignored", 32'(lapa0), 32'd0);

        // 6: clear beats start_stop and tick
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(42);
        check("pre_clear", 32'(disp0), 32'h0042);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("clear_prio_disp", 32'(disp0), 32'h0000);
        check("clear_prio_flags", {29'd0, run0, lapa0, ovf0}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("idle_tick_ignored", 32'(disp0), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
